// File: rtl/tim_apb_master.sv
// APB4 initiator for the timer register block: accepts one valid/ready command,
// runs a single SETUP/ACCESS transfer and returns a one-cycle response pulse.
module tim_apb_master #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              tim_psel,
    output logic              tim_penable,
    output logic              tim_pwrite,
    output logic [ADDR_W-1:0] tim_paddr,
    output logic [31:0]       tim_pwdata,
    output logic [3:0]        tim_pstrb,
    input  logic              tim_pready,
    input  logic [31:0]       tim_prdata,
    input  logic              tim_pslverr
);
    localparam int               CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYC);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERRRSP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr[1:0] == 2'b00) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        pstrb_d  = cmd_write ? cmd_strb : 4'b0000;
                        psel_d   = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        state_d = ERRRSP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so it wins over a coinciding timeout.
                if (tim_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = tim_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !tim_pslverr) ? tim_prdata : '0;
                    state_d       = IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERRRSP: begin
                rsp_valid_d   = 1'b1;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b0;
                rsp_rdata_d   = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign tim_psel    = psel_q;
    assign tim_penable = penable_q;
    assign tim_pwrite  = pwrite_q;
    assign tim_paddr   = paddr_q;
    assign tim_pwdata  = pwdata_q;
    assign tim_pstrb   = pstrb_q;

endmodule

// File: tb/tb_tim_apb_master.sv
// Bench for tim_apb_master: randomized commands against a behavioural APB slave,
// expected responses queued at handshake and checked by an independent monitor.
module tb_tim_apb_master;
    localparam int TO = 4;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          w;
        bit          err;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          lat;
        int          hs;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic        tim_pready   = 1'b0;
    logic [31:0] tim_prdata   = '0;
    logic        tim_pslverr  = 1'b0;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    skip_ready = 1'b0;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    plan_t plan_q[$];
    exp_t  exp_q[$];

    tim_apb_master #(.ADDR_W(12), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_pready(tim_pready), .tim_prdata(tim_prdata), .tim_pslverr(tim_pslverr)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int w, input bit err, input bit track);
        plan_t p;
        exp_t  e;
        int    hs = 0;
        int    n  = 0;
        bit    r;
        bit    mis = (addr[1:0] != 2'b00);
        p = '{wr: wr, addr: addr, wdata: wd, strb: st, w: w, err: err};
        e = '{rdata: '0, err: 1'b0, to: 1'b0, lat: 3 + w, hs: 0};
        if (mis) begin
            e.err = 1'b1; e.lat = 2;
        end else if (w > TO) begin
            e.err = 1'b1; e.to = 1'b1; e.lat = TO + 3;
        end else if (err) begin
            e.err = 1'b1;
        end else if (wr) begin
            ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, st);
        end else begin
            e.rdata = ref_mem[addr[5:2]];
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        forever begin
            r  = cmd_ready;
            hs = cyc + 1;
            @(posedge sys_clk);
            if (r) break;
            @(negedge sys_clk);
            n++;
            if (n > 60) begin
                chk("handshake_wait", 32'(cmd_ready), 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        if (!mis) plan_q.push_back(p);
        if (track) begin
            e.hs = hs;
            exp_q.push_back(e);
        end
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    // Behavioural APB slave: wait states and errors come from the command plan.
    plan_t cur;
    bit    active = 1'b0;
    int    acnt   = 0;
    always @(negedge sys_clk) begin
        if (sys_rst || !tim_psel) begin
            active = 1'b0; tim_pready = 1'b0; tim_pslverr = 1'b0;
        end else if (!tim_penable) begin
            tim_pready = 1'b0;
            if (active) chk("setup_len", 32'(tim_penable), 32'd1);
            else if (plan_q.size() == 0) chk("unexpected_psel", 32'(tim_psel), 32'd0);
            else begin
                cur = plan_q.pop_front();
                active = 1'b1; acnt = 0;
                chk("setup_paddr", 32'(tim_paddr), 32'(cur.addr));
                chk("setup_pwrite", 32'(tim_pwrite), 32'(cur.wr));
                chk("setup_pstrb", 32'(tim_pstrb), cur.wr ? 32'(cur.strb) : 32'd0);
            end
        end else if (!active) begin
            chk("access_no_setup", 32'(active), 32'd1);
        end else begin
            chk("access_paddr", 32'(tim_paddr), 32'(cur.addr));
            chk("access_pwrite", 32'(tim_pwrite), 32'(cur.wr));
            chk("access_pstrb", 32'(tim_pstrb), cur.wr ? 32'(cur.strb) : 32'd0);
            if (cur.wr) chk("access_pwdata", tim_pwdata, cur.wdata);
            if (acnt == cur.w) begin
                tim_pready  = 1'b1;
                tim_pslverr = cur.err;
                tim_prdata  = (cur.wr || cur.err) ? ($urandom | 32'd1) : slv_mem[tim_paddr[5:2]];
                if (cur.wr && !cur.err)
                    slv_mem[tim_paddr[5:2]] = merge(slv_mem[tim_paddr[5:2]], tim_pwdata, tim_pstrb);
                active = 1'b0;
            end else begin
                tim_pready = 1'b0;
                tim_prdata = $urandom;
            end
            acnt++;
        end
    end

    // Response monitor / scoreboard.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst && !skip_ready)
            chk("cmd_ready", 32'(cmd_ready), (rsp_valid || exp_q.size() == 0) ? 32'd1 : 32'd0);
        if (!sys_rst && rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp_latency", 32'(cyc + 1 - e.hs), 32'(e.lat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [11:0] a;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[1] = 32'h1234_5678;
        slv_mem[1] = 32'h1234_5678;
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        repeat (2) @(negedge sys_clk);
        chk("rst_psel", 32'(tim_psel), 32'd0);
        chk("rst_penable", 32'(tim_penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_err", 32'({rsp_err, rsp_timeout, tim_pwrite}), 32'd0);
        chk("rst_paddr", 32'(tim_paddr), 32'd0);
        chk("rst_pstrb", 32'(tim_pstrb), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        issue(1'b1, 12'h000, 32'h0000_0303, 4'hF, 0, 1'b0, 1'b1);
        issue(1'b0, 12'h000, 32'h0,         4'hF, 0, 1'b0, 1'b1);
        issue(1'b0, 12'h004, 32'h0,         4'h0, 3, 1'b0, 1'b1);
        issue(1'b1, 12'h01C, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 1'b1);
        issue(1'b0, 12'h008, 32'h0,         4'h0, 9, 1'b0, 1'b1);
        issue(1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 1'b1);
        issue(1'b0, 12'h00C, 32'h0,         4'h0, TO, 1'b0, 1'b1);
        issue(1'b0, 12'h01C, 32'h0,         4'h0, 1, 1'b1, 1'b1);

        for (int k = 0; k < 200; k++) begin
            a = 12'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 12'($urandom_range(1, 3));
            w = $urandom_range(0, 6);
            issue(1'($urandom), a, $urandom, 4'($urandom), w, ($urandom_range(0, 5) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end

        // Reset during the 2nd ACCESS wait cycle: no response for that command.
        while (exp_q.size() != 0 && cyc < 90000) @(negedge sys_clk);
        skip_ready = 1'b1;
        issue(1'b0, 12'h010, 32'h0, 4'h0, 50, 1'b0, 1'b0);
        repeat (2) @(negedge sys_clk);
        chk("mid_access_penable", 32'({tim_psel, tim_penable}), 32'd3);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("abort_psel", 32'(tim_psel), 32'd0);
        chk("abort_penable", 32'(tim_penable), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        sys_rst = 1'b0;
        skip_ready = 1'b0;
        @(negedge sys_clk);
        issue(1'b0, 12'h004, 32'h0, 4'h0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge sys_clk);
        chk("drain_exp", 32'(exp_q.size()), 32'd0);
        chk("drain_plan", 32'(plan_q.size()), 32'd0);
        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tim_apb_master.md
# tim_apb_master

APB master (initiator) that turns a simple valid/ready command interface into APB4 transfers toward the timer register block, e.g. TCR at 0x000 and TDR0 at 0x004.
- It drives the `tim_*` APB signals the timer slave consumes, tolerates slave wait states, and captures PRDATA/PSLVERR.
- It returns one response per command, aborting hung transfers with a cycle-count timeout.
- It sits between a CPU-side/sequencer command source and `timer_top`, and is reused by the bench as a synthesizable bus driver.

## Interface
Parameters:
- `ADDR_W`, 12, APB address width
- `TIMEOUT_CYC`, 256, max ACCESS cycles waiting for `tim_pready`; 0 disables the timeout

Ports:
- `sys_clk`  in  1  system clock; all logic rising-edge
- `sys_rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  byte address
- `cmd_wdata`  in  32  write data
- `cmd_strb`  in  4  write byte strobes
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `rsp_err`  out  1  slave error, misalignment or timeout
- `rsp_timeout`  out  1  timeout abort (implies `rsp_err`)
- `tim_psel`  out  1  APB PSEL
- `tim_penable`  out  1  APB PENABLE
- `tim_pwrite`  out  1  APB PWRITE
- `tim_paddr`  out  ADDR_W  APB PADDR
- `tim_pwdata`  out  32  APB PWDATA
- `tim_pstrb`  out  4  APB PSTRB
- `tim_pready`  in  1  APB PREADY
- `tim_prdata`  in  32  APB PRDATA
- `tim_pslverr`  in  1  APB PSLVERR; sampled only with `tim_pready`

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERRRSP.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake with `cmd_addr[1:0]`==0: register write/addr/wdata/strb, go to SETUP.
  - On handshake with `cmd_addr[1:0]`!=0: go to ERRRSP with no APB activity.
- **SETUP**
  - `tim_psel`=1, `tim_penable`=0, APB outputs hold the registered command.
  - Always go to ACCESS next edge.
- **ACCESS**
  - `tim_psel`=1, `tim_penable`=1.
  - The timeout counter clears on entry and increments each ACCESS cycle.
  - At an edge where `tim_pready`=1, complete the transfer and go to IDLE:
    - `rsp_valid`=1 next cycle.
    - `rsp_err`=`tim_pslverr`.
    - `rsp_rdata`=`tim_prdata` if read and no pslverr, else 0.
  - If `TIMEOUT_CYC`!=0 and the counter reaches `TIMEOUT_CYC` with `tim_pready` low:
    - Abort and go to IDLE.
    - `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - If `tim_pready` and timeout coincide, `tim_pready` wins (normal completion).
- **ERRRSP**
  - One cycle; `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=0; return to IDLE.
- `cmd_ready`=0 in SETUP, ACCESS and ERRRSP. Commands are never queued.
- `rsp_valid` is a one-cycle pulse with no backpressure. `rsp_*` data fields hold their value until the next response.
- `tim_pstrb` is forced to 4'b0000 on reads.
- `tim_pwrite`/`tim_paddr`/`tim_pwdata`/`tim_pstrb` stay stable from SETUP through the last ACCESS cycle. They keep their last value while idle; only `tim_psel`/`tim_penable` drop.

## Timing
- Reset values: `cmd_ready`=1 (the FSM is in IDLE during and after reset); every other output, including `tim_psel`, `tim_penable`, `rsp_valid`, `rsp_err`, `rsp_timeout`, `tim_pwrite`, `tim_paddr`, `tim_pwdata`, `tim_pstrb`, `rsp_rdata`, is 0. The FSM resets to IDLE and the counter to 0.
- Handshake at edge N:
  - SETUP during cycle N+1.
  - ACCESS from N+2.
  - Zero-wait slave (`tim_pready` high at edge N+2): `rsp_valid` in cycle N+3, which is also back in IDLE with `cmd_ready`=1.
- Minimum 3 cycles per command (new handshake at edge N+3 at the earliest). Each wait state adds 1 cycle.
- Misaligned command: `rsp_valid` in cycle N+2; `tim_psel` never asserts.
- Timeout: with `tim_pready` stuck low, `rsp_valid` occurs `TIMEOUT_CYC`+1 cycles after ACCESS entry.
- `sys_rst` asserted mid-transfer:
  - Next edge: `tim_psel`/`tim_penable` low, state IDLE.
  - No response is generated for the aborted command.

## Test plan
- **Reset state:** hold `sys_rst` 2 cycles.
  - Required: `tim_psel`=`tim_penable`=`rsp_valid`=0, `cmd_ready`=1.
- **Write then read, zero-wait slave:** write 0x000 / 0x0000_0303 / strb 4'hF, then read 0x000.
  - Write: APB shows SETUP→ACCESS, `tim_pstrb`=4'hF, `rsp_valid` 3 cycles after handshake, `rsp_err`=0.
  - Read: `tim_pstrb`=0, `rsp_rdata`=0x0000_0303.
- **Wait states:** read 0x004 with `tim_pready` low for 3 ACCESS cycles, then high with `tim_prdata`=0x1234_5678.
  - Required: `rsp_valid` 6 cycles after handshake, `rsp_rdata`=0x1234_5678, `cmd_ready`=0 throughout.
- **Slave error:** write 0x01C, slave returns `tim_pready`=1 with `tim_pslverr`=1.
  - Required: `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- **Timeout and misalignment:**
  - `TIMEOUT_CYC`=4, `tim_pready` tied low: `rsp_timeout`=1, `rsp_err`=1, PSEL drops after 5 ACCESS cycles.
  - `cmd_addr`=0x006: `rsp_err`=1 in 2 cycles, `tim_psel` never high.
- **Reset mid-ACCESS:** assert `sys_rst` during the 2nd wait cycle.
  - Required: PSEL/PENABLE low next edge, no `rsp_valid`, next command completes normally.
